// File: rtl/uart_rx_frame.sv
// UART receiver front end: 16x-oversampled deserialiser that strobes only
// correctly framed words and flags bad stop bits separately.
module uart_rx_frame #(
    parameter int NB_DATA     = 8,
    parameter int SB_TICK     = 16,
    parameter int NB_TICK_CNT = 5,
    parameter int NB_BIT_CNT  = 3
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam logic [NB_TICK_CNT-1:0] MID_START = NB_TICK_CNT'(7);
    localparam logic [NB_TICK_CNT-1:0] BIT_END   = NB_TICK_CNT'(15);
    localparam logic [NB_TICK_CNT-1:0] STOP_END  = NB_TICK_CNT'(SB_TICK - 1);
    localparam logic [NB_BIT_CNT-1:0]  LAST_BIT  = NB_BIT_CNT'(NB_DATA - 1);

    state_t                  state;
    logic                    rx_meta_p0;
    logic                    rx_s;
    logic [NB_TICK_CNT-1:0]  tick_cnt;
    logic [NB_BIT_CNT-1:0]   bit_cnt;
    logic [NB_DATA-1:0]      shreg;

    // Stage 0/1: two-flop synchroniser; the line idles high, so reset to 1
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_meta_p0 <= i_rx;
            rx_s       <= rx_meta_p0;
        end
    end

    // Stage 2: framing FSM with registered strobes and output word
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (tick_cnt == MID_START) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                bit_cnt <= '0;
                                state   <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + NB_TICK_CNT'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (tick_cnt == BIT_END) begin
                            // LSB arrives first, so right-shift new bits in at the MSB
                            shreg    <= {rx_s, shreg[NB_DATA-1:1]};
                            tick_cnt <= '0;
                            bit_cnt  <= bit_cnt + NB_BIT_CNT'(1);
                            if (bit_cnt == LAST_BIT) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + NB_TICK_CNT'(1);
                        end
                    end
                end
                STOP: begin
                    if (i_tick) begin
                        if (tick_cnt == STOP_END) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                o_data    <= shreg;
                                o_rx_done <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                o_frame_err <= 1'b1;
                                state       <= BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + NB_TICK_CNT'(1);
                        end
                    end
                end
                BREAK: begin
                    // A held-low line must return high before a new start is armed
                    tick_cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: a scoreboard queue of expected strobes is
// filled as frames are sent and drained by a monitor watching the outputs.
module tb_uart_rx_frame;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       rx;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;

    logic       tick_en;
    logic [1:0] tick_div;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model_data;
    int         n_assert;
    int         n_fail;
    int         n_done;
    int         n_err;
    logic       prev_strobe;

    uart_rx_frame #(
        .NB_DATA    (8),
        .SB_TICK    (16),
        .NB_TICK_CNT(5),
        .NB_BIT_CNT (3)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst_n),
        .i_tick     (tick),
        .i_rx       (rx),
        .o_data     (data),
        .o_rx_done  (rx_done),
        .o_frame_err(frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick every 4 clocks, suppressible for the stall scenario
    initial begin
        tick     = 1'b0;
        tick_div = 2'd0;
        forever begin
            @(negedge clk);
            tick_div = tick_div + 2'd1;
            tick     = tick_en && (tick_div == 2'd0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops one expectation per strobe
    initial begin
        exp_t e;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_done || frame_err) begin
                if (rx_done) n_done++;
                if (frame_err) n_err++;
                chk("strobe_exclusive", {31'd0, rx_done && frame_err}, 32'd0);
                chk("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
                chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("strobe_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                    chk("strobe_data", {24'd0, data}, {24'd0, e.data});
                end
            end
            prev_strobe = rx_done || frame_err;
        end
    end

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic lvl, input logic stall);
        rx = lvl;
        if (stall) begin
            idle_clks(20);
            tick_en = 1'b0;
            idle_clks(100);
            tick_en = 1'b1;
            idle_clks(BIT_CLKS - 20);
        end else begin
            idle_clks(BIT_CLKS);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stall_bit);
        exp_t e;
        if (stop_lvl) begin
            e.is_err   = 1'b0;
            e.data     = d;
            model_data = d;
        end else begin
            e.is_err = 1'b1;
            e.data   = model_data;
        end
        sb_q.push_back(e);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], i == stall_bit);
        end
        drive_bit(stop_lvl, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        int budget;
        budget = 400;
        while (sb_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(tag, sb_q.size(), 32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        n_assert   = 0;
        n_fail     = 0;
        n_done     = 0;
        n_err      = 0;
        model_data = 8'h00;
        tick_en    = 1'b1;
        rx         = 1'b1;
        rst_n      = 1'b0;
        idle_clks(4);
        chk("reset_data", {24'd0, data}, 32'd0);
        chk("reset_done", {31'd0, rx_done}, 32'd0);
        chk("reset_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        idle_clks(BIT_CLKS);

        // Good frame
        send_frame(8'hA5, 1'b1, -1);
        wait_drain("good_drain");
        chk("good_data", {24'd0, data}, 32'h0000_00A5);
        chk("good_done_cnt", n_done, 32'd1);
        chk("good_err_cnt", n_err, 32'd0);

        // Back-to-back, no idle gap
        send_frame(8'h03, 1'b1, -1);
        send_frame(8'h05, 1'b1, -1);
        send_frame(8'h20, 1'b1, -1);
        wait_drain("b2b_drain");
        chk("b2b_done_cnt", n_done, 32'd4);
        chk("b2b_data", {24'd0, data}, 32'h0000_0020);
        rx = 1'b1;
        idle_clks(BIT_CLKS);

        // Start-bit glitch of 4 ticks
        d0 = n_done;
        rx = 1'b0;
        idle_clks(16);
        rx = 1'b1;
        idle_clks(2 * BIT_CLKS);
        chk("glitch_no_strobe", n_done - d0, 32'd0);
        chk("glitch_data_held", {24'd0, data}, 32'h0000_0020);
        send_frame(8'h3C, 1'b1, -1);
        wait_drain("glitch_drain");
        chk("glitch_next_data", {24'd0, data}, 32'h0000_003C);
        idle_clks(BIT_CLKS);

        // Framing error followed by a long break
        send_frame(8'h11, 1'b1, -1);
        d0 = n_done;
        e0 = n_err;
        send_frame(8'hFF, 1'b0, -1);
        rx = 1'b0;
        idle_clks(20 * BIT_CLKS);
        rx = 1'b1;
        idle_clks(2 * BIT_CLKS);
        wait_drain("ferr_drain");
        chk("ferr_err_cnt", n_err - e0, 32'd1);
        chk("ferr_no_done", n_done - d0, 32'd0);
        chk("ferr_data_held", {24'd0, data}, 32'h0000_0011);
        send_frame(8'h42, 1'b1, -1);
        wait_drain("ferr_next_drain");
        chk("ferr_next_data", {24'd0, data}, 32'h0000_0042);
        idle_clks(BIT_CLKS);

        // Reset during data bit 3 of 0x99; the sender aborts with the reset
        d0 = n_done;
        e0 = n_err;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_bit(1'(8'h99 >> i), 1'b0);
        end
        rx = 1'b1;
        idle_clks(30);
        rst_n = 1'b0;
        idle_clks(2);
        rst_n      = 1'b1;
        model_data = 8'h00;
        chk("mid_reset_data", {24'd0, data}, 32'd0);
        idle_clks(20 * BIT_CLKS);
        chk("mid_reset_no_done", n_done - d0, 32'd0);
        chk("mid_reset_no_err", n_err - e0, 32'd0);
        chk("mid_reset_data_idle", {24'd0, data}, 32'd0);
        send_frame(8'h7E, 1'b1, -1);
        wait_drain("mid_reset_drain");
        chk("mid_reset_next_cnt", n_done - d0, 32'd1);
        chk("mid_reset_next_data", {24'd0, data}, 32'h0000_007E);
        idle_clks(BIT_CLKS);

        // Tick stall inside data bit 5
        send_frame(8'h5A, 1'b1, 5);
        wait_drain("stall_drain");
        chk("stall_data", {24'd0, data}, 32'h0000_005A);
        chk("stall_err_total", n_err, 32'd1);
        idle_clks(BIT_CLKS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Upstream stage of the operand/opcode collector.
- Deserialises the asynchronous UART line into NB_DATA-bit words using 16x oversampling ticks from the shared baud-rate generator.
- Emits a one-clock o_rx_done strobe per correctly framed word; this strobe drives the collector's valid input.
- Words with a bad stop bit are flagged on o_frame_err and never strobed, so the collector's three-word A/B/op sequence is not corrupted.

Parameters:
- NB_DATA, 8: data bits per frame, LSB first.
- SB_TICK, 16: oversampling ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- NB_TICK_CNT, 5: width of the tick counter; must hold SB_TICK-1.
- NB_BIT_CNT, 3: width of the bit counter; must hold NB_DATA-1.

Ports:
- i_clock, input, 1: system clock; all logic on the rising edge.
- i_reset, input, 1: synchronous, active-low reset (0 = reset).
- i_tick, input, 1: one-clock pulse at 16x baud rate.
- i_rx, input, 1: raw serial line, idle high, asynchronous to i_clock.
- o_data, output, NB_DATA: last correctly received word.
- o_rx_done, output, 1: one-clock strobe, new word valid on o_data.
- o_frame_err, output, 1: one-clock strobe, stop bit sampled low.

Behaviour:
- Reset (sampled when i_reset==0 on a clock edge):
  - o_data=0, o_rx_done=0, o_frame_err=0, state=IDLE, counters=0, shift register=0.
  - Both synchroniser flops = 1.
  - Reset overrides everything, including a frame in progress; the partial frame is discarded.
- Synchroniser: i_rx passes through two flops; only the second-stage value (rx_s) is used. This adds 2 clocks of latency.
- Tick gating: all counters advance only on cycles with i_tick==1. With i_tick==0, state and counters hold.
- States:
  - IDLE: tick_cnt=0. When rx_s==0, go to START (no tick required).
  - START: on each tick, tick_cnt++. When a tick arrives with tick_cnt==7 (mid start bit):
    - rx_s==0: tick_cnt=0, bit_cnt=0, go to DATA.
    - rx_s==1: glitch; go to IDLE with no outputs.
  - DATA: on each tick, tick_cnt++. When a tick arrives with tick_cnt==15:
    - Shift rx_s into the MSB of the shift register (right shift, so LSB-first order lands correctly).
    - tick_cnt=0, bit_cnt++.
    - When the bit just taken is number NB_DATA-1, go to STOP.
  - STOP: on each tick, tick_cnt++. When a tick arrives with tick_cnt==SB_TICK-1:
    - rx_s==1: o_data <= shift register; o_rx_done=1 for exactly the next clock; go to IDLE.
    - rx_s==0: o_frame_err=1 for exactly the next clock; o_data unchanged; go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line (break) from retriggering reception.
- Output timing:
  - o_rx_done and o_frame_err are registered.
  - They never assert in the same cycle and are never high for two consecutive cycles.
- o_data holds its value until the next good frame; it is stable whenever o_rx_done==1.
- Back-to-back frames: a start edge arriving immediately after the stop sample is accepted, because IDLE re-arms on the same cycle the FSM returns to it.
- Bit timing: total latency from the falling start edge to o_rx_done is approximately (8 + 16*NB_DATA + SB_TICK) ticks + 3 clocks.

Test Plan:
- Setup for all scenarios: i_tick every 4 clocks, 1 bit = 64 clocks.
- Good frame: send 0xA5 with 1 stop bit -> exactly one o_rx_done pulse, o_data=0xA5, o_frame_err never high.
- Back-to-back frames: send 0x03, 0x05, 0x20 with no idle gap -> three o_rx_done pulses; o_data reads 0x03, 0x05, 0x20 on the respective strobes.
- Start-bit glitch: drive i_rx low for 4 ticks, then high -> no strobe, FSM back in IDLE; then send 0x3C -> o_data=0x3C.
- Framing error: after a good 0x11, send 0xFF with stop bit 0, then hold i_rx low for 20 bit times and release -> one o_frame_err pulse, no o_rx_done, o_data stays 0x11, no spurious frame during the break; then send 0x42 -> o_data=0x42.
- Mid-frame reset: drive i_reset=0 for 2 clocks during data bit 3 of 0x99 -> o_data=0 and no strobes; then send 0x7E -> one o_rx_done, o_data=0x7E.
- Tick stall: hold i_tick=0 for 100 clocks in the middle of data bit 5 of 0x5A, with the line level held -> state frozen; after ticks resume, o_data=0x5A.
